seven_seg_scanner: RTL and testbench



---
 rtl/seven_seg_pkg.sv | 25 ++
 rtl/binary_segment.sv | 30 +++
 rtl/seven_seg_scanner.sv | 120 ++++++++++++
 tb/tb_seven_seg_scanner.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the seven-segment scanner.
// Also provides the leading-zero test used when LEADING_ZERO_SUPPRESS_EN is defined.
package seven_seg_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam logic [6:0]  SEG_OFF    = 7'h7F;
    localparam logic [3:0]  AN_OFF     = 4'hF;

    typedef enum logic {BLANK, DRIVE} state_t;

    typedef logic [1:0] digit_idx_t;

    // True when idx is not the units digit and every nibble from idx upward is zero.
    function automatic logic lz_suppress(input logic [15:0] v, input digit_idx_t idx);
        logic zero;
        zero = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (i >= 32'(idx)) begin
                zero = zero & (v[i*4 +: 4] == 4'h0);
            end
        end
        return zero && (idx != 2'd0);
    endfunction

endpackage

// File: rtl/binary_segment.sv
// Hex nibble to seven-segment decoder for a common-anode display.
// Output order is {g,f,e,d,c,b,a}; a 1 turns the segment off.
module binary_segment (
    input  logic [3:0] bin,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        unique case (bin)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 4-digit common-anode display driver with inter-digit blanking.
// Optional macro LEADING_ZERO_SUPPRESS_EN turns off leading zero digits 3..1.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic        load,
    input  logic [3:0]  blank,
    output logic [3:0]  bin,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic [1:0]  digit_idx
);

    localparam int unsigned      CNT_W      = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      shadow_q, shadow_d;
    digit_idx_t       digit_idx_q, digit_idx_d;
    logic [3:0]       bin_q, bin_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;

    logic       wrap;
    logic       enter_drive;
    logic       suppress;
    logic [3:0] nibble_sel;
    logic [6:0] seg_dec;

    assign wrap        = (cnt_q == CNT_LAST);
    assign enter_drive = (cnt_q == BLANK_LAST);
    assign nibble_sel  = shadow_q[{digit_idx_q, 2'b00} +: 4];

    binary_segment u_dec (
        .bin (nibble_sel),
        .seg (seg_dec)
    );

`ifdef LEADING_ZERO_SUPPRESS_EN
    assign suppress = blank[digit_idx_q] | lz_suppress(shadow_q, digit_idx_q);
`else
    assign suppress = blank[digit_idx_q];
`endif

    always_comb begin
        shadow_d    = load ? value : shadow_q;
        cnt_d       = wrap ? '0 : cnt_q + CNT_W'(1);
        digit_idx_d = wrap ? digit_idx_q + 2'd1 : digit_idx_q;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BLANK;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BLANK: if (enter_drive) state_d = DRIVE;
            DRIVE: if (wrap)        state_d = BLANK;
        endcase
    end

    // FSM outputs: bin, seg and an are all loaded on the same edge to avoid skew
    always_comb begin
        bin_d = bin_q;
        seg_d = seg_q;
        an_d  = an_q;
        if (state_q == BLANK && enter_drive) begin
            bin_d = nibble_sel;
            if (suppress) begin
                an_d  = AN_OFF;
                seg_d = SEG_OFF;
            end else begin
                an_d  = ~(4'b0001 << digit_idx_q);
                seg_d = seg_dec;
            end
        end else if (state_q == DRIVE && wrap) begin
            an_d  = AN_OFF;
            seg_d = SEG_OFF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            shadow_q    <= '0;
            digit_idx_q <= '0;
            bin_q       <= '0;
            seg_q       <= SEG_OFF;
            an_q        <= AN_OFF;
        end else begin
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            digit_idx_q <= digit_idx_d;
            bin_q       <= bin_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign bin       = bin_q;
    assign seg       = seg_q;
    assign an        = an_q;
    assign digit_idx = digit_idx_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner with REFRESH_DIV=8, BLANK_CYCLES=2.
// Build with LEADING_ZERO_SUPPRESS_EN defined to exercise leading-zero suppression.
module tb_seven_seg_scanner;

    localparam int unsigned RD = 8;
    localparam int unsigned BC = 2;
    localparam int unsigned NSLOT = 23;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic        load;
    logic [3:0]  blank;
    logic [3:0]  bin;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [1:0]  digit_idx;

    seven_seg_scanner #(
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .value     (value),
        .load      (load),
        .blank     (blank),
        .bin       (bin),
        .seg       (seg),
        .an        (an),
        .digit_idx (digit_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        int unsigned ld_cyc;
        logic [15:0] val;
        logic [3:0]  blank;
    } stim_t;

    typedef struct {
        logic [1:0] digit;
        logic [3:0] bin;
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    stim_t       tbl [NSLOT];
    exp_t        sb [$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [15:0] m_shadow;
    logic [1:0]  m_digit;

    function automatic logic [6:0] seg_model(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic is_suppressed(input logic [15:0] sh, input logic [1:0] d,
                                           input logic [3:0] bl);
        logic s;
        s = bl[d];
`ifdef LEADING_ZERO_SUPPRESS_EN
        case (d)
            2'd1: s = s | (sh[15:4]  == 12'h000);
            2'd2: s = s | (sh[15:8]  == 8'h00);
            2'd3: s = s | (sh[15:12] == 4'h0);
            default: ;
        endcase
`endif
        return s;
    endfunction

    function automatic stim_t mk(input logic ld, input int unsigned cyc,
                                 input logic [15:0] val, input logic [3:0] bl);
        stim_t s;
        s.ld = ld; s.ld_cyc = cyc; s.val = val; s.blank = bl;
        return s;
    endfunction

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Entered #1 after the edge that put the slot counter at 0; leaves at the same point of the next slot.
    task automatic run_slot(input stim_t s);
        exp_t e;
        e = '{digit: 2'd0, bin: 4'h0, an: 4'hF, seg: 7'h7F};
        for (int unsigned c = 0; c < RD; c++) begin
            chk("one_anode", ($countones(~an) <= 1) ? 1 : 0, 1);
            if (c == 0) begin
                chk("slot_start_an", an, 4'hF);
                chk("slot_start_seg", seg, 7'h7F);
                chk("digit_idx", digit_idx, m_digit);
            end
            if (c == 1) chk("blank_an", an, 4'hF);
            load  = s.ld && (c == s.ld_cyc);
            value = s.val;
            blank = s.blank;
            if (c == BC - 1) begin
                e.digit = m_digit;
                e.bin   = m_shadow[m_digit*4 +: 4];
                if (is_suppressed(m_shadow, m_digit, s.blank)) begin
                    e.an  = 4'hF;
                    e.seg = 7'h7F;
                end else begin
                    e.an  = ~(4'b0001 << m_digit);
                    e.seg = seg_model(e.bin);
                end
                sb.push_back(e);
            end
            if (load) m_shadow = s.val;
            tick();
            load = 1'b0;
            if (c == BC - 1) begin
                if (sb.size() == 0) begin
                    chk("scoreboard_empty", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("drive_an", an, e.an);
                    chk("drive_seg", seg, e.seg);
                    chk("drive_bin", bin, e.bin);
                end
            end
            if (c == RD - 2) begin
                chk("hold_an", an, e.an);
                chk("hold_seg", seg, e.seg);
                chk("hold_bin", bin, e.bin);
            end
        end
        m_digit = m_digit + 2'd1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mk(1'b1, 0, 16'h4210, 4'b0000);
        tbl[1]  = mk(1'b0, 0, 16'hDEAD, 4'b0000);
        tbl[2]  = mk(1'b0, 0, 16'hDEAD, 4'b0000);
        tbl[3]  = mk(1'b0, 0, 16'hDEAD, 4'b0000);
        tbl[4]  = mk(1'b1, 0, 16'h0000, 4'b0000);
        tbl[5]  = mk(1'b1, 1, 16'hFFFF, 4'b0000);
        tbl[6]  = mk(1'b0, 0, 16'h5555, 4'b0000);
        tbl[7]  = mk(1'b1, 4, 16'h1234, 4'b0000);
        tbl[8]  = mk(1'b0, 0, 16'h0000, 4'b0100);
        tbl[9]  = mk(1'b0, 0, 16'h0000, 4'b0100);
        tbl[10] = mk(1'b0, 0, 16'h0000, 4'b0100);
        tbl[11] = mk(1'b0, 0, 16'h0000, 4'b0100);
        tbl[12] = mk(1'b1, 0, 16'h0005, 4'b0000);
        tbl[13] = mk(1'b0, 0, 16'h0000, 4'b0000);
        tbl[14] = mk(1'b0, 0, 16'h0000, 4'b0000);
        tbl[15] = mk(1'b0, 0, 16'h0000, 4'b0000);
        tbl[16] = mk(1'b1, 0, 16'h8765, 4'b0000);
        tbl[17] = mk(1'b0, 0, 16'h0000, 4'b0000);
        tbl[18] = mk(1'b0, 0, 16'h0000, 4'b0000);
        tbl[19] = mk(1'b1, 0, 16'hC0DE, 4'b0000);
        tbl[20] = mk(1'b0, 0, 16'h0000, 4'b0000);
        tbl[21] = mk(1'b0, 0, 16'h0000, 4'b0000);
        tbl[22] = mk(1'b0, 0, 16'h0000, 4'b0000);

        rst_n = 1'b0;
        value = 16'h0000;
        load  = 1'b0;
        blank = 4'b0000;
        repeat (5) tick();
        chk("reset_an", an, 4'hF);
        chk("reset_seg", seg, 7'h7F);
        chk("reset_bin", bin, 4'h0);
        chk("reset_digit_idx", digit_idx, 2'd0);
        rst_n    = 1'b1;
        m_shadow = 16'h0000;
        m_digit  = 2'd0;

        for (int unsigned i = 0; i < 19; i++) run_slot(tbl[i]);

        // Digit 3 of 16'h8765 is mid-DRIVE; reset lands between clock edges.
        repeat (4) tick();
        chk("pre_reset_an", an, is_suppressed(m_shadow, 2'd3, 4'b0000) ? 4'hF : 4'h7);
        chk("pre_reset_bin", bin, 4'h8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_an", an, 4'hF);
        chk("async_reset_seg", seg, 7'h7F);
        chk("async_reset_bin", bin, 4'h0);
        chk("async_reset_digit_idx", digit_idx, 2'd0);
        repeat (3) tick();
        rst_n    = 1'b1;
        m_shadow = 16'h0000;
        m_digit  = 2'd0;

        for (int unsigned i = 19; i < NSLOT; i++) run_slot(tbl[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
